// File: rtl/trig_gen_pkg.sv
// trig_gen_pkg: shared FSM state and edge-mode encodings for the trigger generator.
package trig_gen_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EDGE_RISE     = 2'b00,
        EDGE_FALL     = 2'b01,
        EDGE_BOTH     = 2'b10,
        EDGE_RISE_ALT = 2'b11
    } edge_mode_t;
endpackage

// File: rtl/trig_debounce.sv
// trig_debounce: holds a stable level that follows value only after length consecutive differing cycles.
module trig_debounce #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_aresetn,
    input  logic             value,
    input  logic             reload,
    input  logic [CNT_W-1:0] length,
    output logic             stable
);
    logic [CNT_W-1:0] cnt;

    // A return to the stable level, a reload or a zero length all follow value directly.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (reload || length == '0 || value == stable) begin
            stable <= value;
            cnt    <= '0;
        end else if (cnt >= length - 1'b1) begin
            stable <= value;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/trig_gen_mc.sv
// trig_gen_mc: multi-source trigger generator with sync, debounce, edge select,
// edge divider and a pulse/holdoff FSM.
module trig_gen_mc
    import trig_gen_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic [N_SRC-1:0]         i_src,
    input  logic [$clog2(N_SRC)-1:0] i_sel,
    input  logic                     i_enable,
    input  logic [1:0]               i_edge_mode,
    input  logic [CNT_W-1:0]         i_deb_cycles,
    input  logic [CNT_W-1:0]         i_div,
    input  logic [CNT_W-1:0]         i_pulse_len,
    input  logic [CNT_W-1:0]         i_holdoff,
    input  logic                     i_soft_trig,
    output logic                     o_trigger,
    output logic                     o_busy,
    output logic                     o_missed,
    output logic [31:0]              o_trig_count
);
    logic [N_SRC-1:0]         sync_q [SYNC_STAGES];
    logic [$clog2(N_SRC)-1:0] sel_eff, sel_q;
    logic                     reload, reload_q, stable, stable_d, rise, fall, edge_hit, fire, start;
    logic [CNT_W-1:0]         div_cnt, div_last, pulse_last, timer, timer_n, hold_q, hold_n;
    state_t                   state, state_n;
    edge_mode_t               mode;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_src;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sel_eff = (int'(i_sel) < N_SRC) ? i_sel : '0;
    assign reload  = i_sel != sel_q;

    trig_debounce #(.CNT_W(CNT_W)) u_deb (
        .i_clk    (i_clk),
        .i_aresetn(i_aresetn),
        .value    (sync_q[SYNC_STAGES-1][sel_eff]),
        .reload   (reload),
        .length   (i_deb_cycles),
        .stable   (stable)
    );

    // Edges are masked both in the select-change cycle and the cycle the reloaded level appears.
    assign mode       = edge_mode_t'(i_edge_mode);
    assign rise       = stable & ~stable_d;
    assign fall       = ~stable & stable_d;
    assign edge_hit   = ((mode == EDGE_FALL) ? fall : (mode == EDGE_BOTH) ? (rise | fall) : rise)
                        & i_enable & ~reload & ~reload_q;
    assign div_last   = (i_div == '0) ? '0 : i_div - 1'b1;
    assign pulse_last = (i_pulse_len == '0) ? '0 : i_pulse_len - 1'b1;
    assign fire       = edge_hit && state == IDLE && div_cnt >= div_last;
    assign start      = state == IDLE && i_enable && (fire || i_soft_trig);

    always_comb begin
        state_n = state;
        timer_n = timer;
        hold_n  = hold_q;
        if (state == IDLE) begin
            if (start) begin
                state_n = PULSE;
                timer_n = pulse_last;
                hold_n  = i_holdoff;
            end
        end else if (timer != '0) begin
            timer_n = timer - 1'b1;
        end else if (state == PULSE && hold_q != '0) begin
            state_n = HOLDOFF;
            timer_n = hold_q - 1'b1;
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            sel_q        <= '0;
            reload_q     <= 1'b0;
            stable_d     <= 1'b0;
            div_cnt      <= '0;
            state        <= IDLE;
            timer        <= '0;
            hold_q       <= '0;
            o_trigger    <= 1'b0;
            o_missed     <= 1'b0;
            o_trig_count <= '0;
        end else begin
            sel_q        <= i_sel;
            reload_q     <= reload;
            stable_d     <= stable;
            div_cnt      <= (!i_enable || fire) ? '0 : div_cnt + CNT_W'(edge_hit && state == IDLE);
            state        <= state_n;
            timer        <= timer_n;
            hold_q       <= hold_n;
            o_trigger    <= state_n == PULSE;
            o_missed     <= edge_hit && state != IDLE;
            o_trig_count <= o_trig_count + {31'd0, start};
        end
    end

    assign o_busy = state != IDLE;
endmodule

// File: tb/tb_trig_gen_mc.sv
// tb_trig_gen_mc: scenario tasks plus randomized edge trains checked against
// a pulse/edge arithmetic model.
module tb_trig_gen_mc;
    logic        i_clk = 1'b0;
    logic        i_aresetn = 1'b0;
    logic [3:0]  i_src = '0;
    logic [1:0]  i_sel = '0;
    logic        i_enable = 1'b0;
    logic [1:0]  i_edge_mode = '0;
    logic [15:0] i_deb_cycles = '0, i_div = '0, i_pulse_len = '0, i_holdoff = '0;
    logic        i_soft_trig = 1'b0;
    logic        o_trigger, o_busy, o_missed;
    logic [31:0] o_trig_count;

    int n_cmp = 0, n_err = 0;
    int n_pulse = 0, n_hi = 0, n_busy = 0, n_miss = 0;
    logic prev_trig = 1'b0;

    trig_gen_mc dut (
        .i_clk       (i_clk),
        .i_aresetn   (i_aresetn),
        .i_src       (i_src),
        .i_sel       (i_sel),
        .i_enable    (i_enable),
        .i_edge_mode (i_edge_mode),
        .i_deb_cycles(i_deb_cycles),
        .i_div       (i_div),
        .i_pulse_len (i_pulse_len),
        .i_holdoff   (i_holdoff),
        .i_soft_trig (i_soft_trig),
        .o_trigger   (o_trigger),
        .o_busy      (o_busy),
        .o_missed    (o_missed),
        .o_trig_count(o_trig_count)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_trigger && !prev_trig) n_pulse++;
        if (o_trigger) n_hi++;
        if (o_busy) n_busy++;
        if (o_missed) n_miss++;
        prev_trig = o_trigger;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic setup(input int sel, input int mode, input int deb, input int div, input int plen, input int hold);
        i_enable = 1'b0;
        i_src = '0;
        i_soft_trig = 1'b0;
        ticks(12);
        i_sel = 2'(sel);
        i_edge_mode = 2'(mode);
        i_deb_cycles = 16'(deb);
        i_div = 16'(div);
        i_pulse_len = 16'(plen);
        i_holdoff = 16'(hold);
        ticks(12);
        i_enable = 1'b1;
        ticks(2);
    endtask

    task automatic wait_trig(input int budget, output int k);
        k = 0;
        for (int j = 1; j <= budget; j++) begin
            tick();
            if (o_trigger) begin
                k = j;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_aresetn = 1'b0;
        ticks(3);
        n_cmp++; if (o_trigger !== 1'b0) begin n_err++; $display("FAIL reset_trigger: got %b want 0", o_trigger); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_missed !== 1'b0) begin n_err++; $display("FAIL reset_missed: got %b want 0", o_missed); end
        n_cmp++; if (o_trig_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_trig_count); end
        i_aresetn = 1'b1;
        ticks(4);
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_trig_count !== 32'd0) begin n_err++; $display("FAIL idle_count: got %0d want 0", o_trig_count); end
    endtask

    task automatic test_latency();
        int lat = 0, hi = 0;
        setup(2, 0, 0, 1, 3, 0);
        i_src[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (o_trigger) begin
                hi++;
                if (lat == 0) lat = k;
            end
        end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL latency: got %0d want 4", lat); end
        n_cmp++; if (hi !== 3) begin n_err++; $display("FAIL latency_width: got %0d want 3", hi); end
        n_cmp++; if (o_trig_count !== 32'd1) begin n_err++; $display("FAIL latency_count: got %0d want 1", o_trig_count); end
    endtask

    task automatic test_debounce();
        int p0;
        setup(2, 0, 5, 1, 2, 0);
        p0 = n_pulse;
        repeat (3) begin
            i_src[2] = 1'b1;
            ticks(4);
            i_src[2] = 1'b0;
            ticks(10);
        end
        n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL debounce_glitch: got %0d pulses want 0", n_pulse - p0); end
        i_src[2] = 1'b1;
        ticks(6);
        i_src[2] = 1'b0;
        ticks(20);
        n_cmp++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL debounce_level: got %0d pulses want 1", n_pulse - p0); end
    endtask

    task automatic test_divider();
        int p0;
        setup(2, 2, 0, 3, 2, 0);
        p0 = n_pulse;
        for (int i = 1; i <= 6; i++) begin
            i_src[2] = ~i_src[2];
            ticks(10);
            n_cmp++; if (n_pulse - p0 !== i / 3) begin n_err++; $display("FAIL divider_edge%0d: got %0d pulses want %0d", i, n_pulse - p0, i / 3); end
        end
    endtask

    task automatic test_holdoff();
        int p0, m0, b0, h0, k;
        setup(2, 0, 0, 1, 4, 10);
        p0 = n_pulse; m0 = n_miss; b0 = n_busy; h0 = n_hi;
        i_src[2] = 1'b1;
        wait_trig(10, k);
        n_cmp++; if (k !== 4) begin n_err++; $display("FAIL holdoff_first: got latency %0d want 4", k); end
        tick();
        i_src[2] = 1'b0;
        ticks(2);
        i_src[2] = 1'b1;
        ticks(30);
        n_cmp++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL holdoff_pulses: got %0d want 1", n_pulse - p0); end
        n_cmp++; if (n_miss - m0 !== 1) begin n_err++; $display("FAIL holdoff_missed: got %0d cycles want 1", n_miss - m0); end
        n_cmp++; if (n_busy - b0 !== 14) begin n_err++; $display("FAIL holdoff_busy: got %0d cycles want 14", n_busy - b0); end
        n_cmp++; if (n_hi - h0 !== 4) begin n_err++; $display("FAIL holdoff_width: got %0d cycles want 4", n_hi - h0); end
    endtask

    task automatic test_soft();
        int p0, h0, k;
        logic [31:0] c0;
        setup(2, 0, 0, 1, 4, 0);
        p0 = n_pulse; h0 = n_hi; c0 = o_trig_count;
        i_src[2] = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 3) i_soft_trig = 1'b1;
            if (j == 4) begin
                i_soft_trig = 1'b0;
                n_cmp++; if (o_trigger !== 1'b1) begin n_err++; $display("FAIL simul_rise: got %b want 1", o_trigger); end
            end
        end
        n_cmp++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL simul_pulses: got %0d want 1", n_pulse - p0); end
        n_cmp++; if (n_hi - h0 !== 4) begin n_err++; $display("FAIL simul_width: got %0d want 4", n_hi - h0); end
        n_cmp++; if (o_trig_count !== c0 + 1) begin n_err++; $display("FAIL simul_count: got %0d want %0d", o_trig_count, c0 + 1); end
        i_soft_trig = 1'b1;
        tick();
        i_soft_trig = 1'b0;
        n_cmp++; if (o_trigger !== 1'b1) begin n_err++; $display("FAIL soft_only: got %b want 1", o_trigger); end
        i_soft_trig = 1'b1;
        tick();
        i_soft_trig = 1'b0;
        ticks(10);
        n_cmp++; if (o_trig_count !== c0 + 2) begin n_err++; $display("FAIL soft_busy_drop: got %0d want %0d", o_trig_count, c0 + 2); end
        i_src[2] = 1'b0;
        ticks(10);
        i_src[2] = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j == 3) i_soft_trig = 1'b1;
            if (j == 4) i_soft_trig = 1'b0;
        end
        n_cmp++; if (o_trigger !== 1'b1) begin n_err++; $display("FAIL midpulse_high: got %b want 1", o_trigger); end
        i_aresetn = 1'b0;
        #1;
        n_cmp++; if (o_trigger !== 1'b0) begin n_err++; $display("FAIL midreset_trigger: got %b want 0", o_trigger); end
        n_cmp++; if (o_trig_count !== 32'd0) begin n_err++; $display("FAIL midreset_count: got %0d want 0", o_trig_count); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", o_busy); end
        tick();
        i_aresetn = 1'b1;
        wait_trig(10, k);
        n_cmp++; if (k !== 4) begin n_err++; $display("FAIL postreset_edge: got latency %0d want 4", k); end
        n_cmp++; if (o_trig_count !== 32'd1) begin n_err++; $display("FAIL postreset_count: got %0d want 1", o_trig_count); end
        ticks(10);
    endtask

    task automatic test_sel_switch();
        int p0;
        setup(2, 0, 0, 1, 2, 0);
        p0 = n_pulse;
        i_src[1] = 1'b1;
        ticks(10);
        i_sel = 2'd1;
        ticks(20);
        n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL sel_switch_quiet: got %0d pulses want 0", n_pulse - p0); end
        i_src[1] = 1'b0;
        ticks(10);
        i_src[1] = 1'b1;
        ticks(15);
        n_cmp++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL sel_switch_edge: got %0d pulses want 1", n_pulse - p0); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int sel, mode, deb, div, plen, hold, nt, acc, exp_p, plen_eff, p0, h0, b0, m0;
            logic lvl;
            sel = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            deb = $urandom_range(0, 3);
            div = $urandom_range(0, 4);
            plen = $urandom_range(0, 4);
            hold = $urandom_range(0, 5);
            nt = $urandom_range(3, 9);
            acc = 0;
            lvl = 1'b0;
            setup(sel, mode, deb, div, plen, hold);
            p0 = n_pulse; h0 = n_hi; b0 = n_busy; m0 = n_miss;
            for (int j = 0; j < nt; j++) begin
                lvl = ~lvl;
                i_src[sel] = lvl;
                ticks(30);
                if (mode == 1 ? !lvl : mode == 2 ? 1'b1 : lvl) acc++;
            end
            exp_p = acc / (div == 0 ? 1 : div);
            plen_eff = plen == 0 ? 1 : plen;
            n_cmp++; if (n_pulse - p0 !== exp_p) begin n_err++; $display("FAIL rand%0d_pulses: got %0d want %0d", it, n_pulse - p0, exp_p); end
            n_cmp++; if (n_hi - h0 !== exp_p * plen_eff) begin n_err++; $display("FAIL rand%0d_high: got %0d want %0d", it, n_hi - h0, exp_p * plen_eff); end
            n_cmp++; if (n_busy - b0 !== exp_p * (plen_eff + hold)) begin n_err++; $display("FAIL rand%0d_busy: got %0d want %0d", it, n_busy - b0, exp_p * (plen_eff + hold)); end
            n_cmp++; if (n_miss - m0 !== 0) begin n_err++; $display("FAIL rand%0d_missed: got %0d want 0", it, n_miss - m0); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_debounce();
        test_divider();
        test_holdoff();
        test_soft();
        test_sel_switch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/trig_gen_mc.md
TRIG_GEN_MC -- requirements
Module: trig_gen_mc

Interface
REQ-001 Parameter N_SRC, default 4: number of trigger source inputs (>=2).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per source (>=2).
REQ-003 Parameter CNT_W, default 16: width of the debounce, divider, pulse and holdoff counters.
REQ-004 i_clk  in  1  system clock; all logic is on its rising edge.
REQ-005 i_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 i_src  in  N_SRC  asynchronous trigger sources (external lines, encoder step, ...).
REQ-007 i_sel  in  $clog2(N_SRC)  selected source index; values >=N_SRC select source 0.
REQ-008 i_enable  in  1  arms the block; 0 = ignore all sources.
REQ-009 i_edge_mode  in  2  00 rising, 01 falling, 10 both, 11 treated as rising.
REQ-010 i_deb_cycles  in  CNT_W  debounce stability length; 0 = bypass.
REQ-011 i_div  in  CNT_W  fire on every i_div-th accepted edge; 0 and 1 both mean every edge.
REQ-012 i_pulse_len  in  CNT_W  o_trigger high time in cycles; 0 treated as 1.
REQ-013 i_holdoff  in  CNT_W  dead time after the pulse in cycles; 0 = none.
REQ-014 i_soft_trig  in  1  single-cycle software trigger, synchronous to i_clk.
REQ-015 o_trigger  out  1  registered trigger pulse.
REQ-016 o_busy  out  1  high whenever the state is not IDLE.
REQ-017 o_missed  out  1  one-cycle flag: an edge arrived while busy and was dropped.
REQ-018 o_trig_count  out  32  count of pulses issued; wraps modulo 2^32.

Function
REQ-019 Every source bit passes through its own SYNC_STAGES-flop synchroniser; the mux on i_sel follows the synchronisers.
REQ-020 Debouncer, deb_cycles > 0: the stable output takes the muxed value only after that value has differed from it for i_deb_cycles consecutive cycles. Any return to the stable value restarts the count.
REQ-021 Debouncer, deb_cycles = 0: the stable output is the muxed value registered once.
REQ-022 On any change of i_sel, the stable value reloads from the new source without counting, and edge detection is suppressed for that cycle.
REQ-023 Edge detection is combinational from the stable value and its one-cycle delayed copy, filtered by i_edge_mode.
REQ-024 An edge is accepted only when i_enable=1 and the state is IDLE.
REQ-025 Each accepted edge increments the divider count. On reaching max(i_div,1), the count clears and a fire is issued.
REQ-026 With deb=0, div<=1 and SYNC_STAGES=2, o_trigger rises on the 4th clock edge after i_src is first sampled high (latency SYNC_STAGES+2).
REQ-027 FSM states IDLE, PULSE, HOLDOFF.
REQ-028 IDLE -> PULSE on a fire, or on i_soft_trig with i_enable=1. A simultaneous hardware fire and soft trigger yield one pulse.
REQ-029 PULSE holds o_trigger=1 for exactly max(i_pulse_len,1) cycles.
REQ-030 At the end of PULSE the FSM goes to HOLDOFF for i_holdoff cycles if i_holdoff>0, otherwise to IDLE.
REQ-031 An edge detected with i_enable=1 in PULSE or HOLDOFF asserts o_missed for 1 cycle and does not touch the divider. A soft trigger while busy is dropped silently.
REQ-032 o_trig_count increments by 1 on each IDLE -> PULSE transition.
REQ-033 i_enable low clears the divider count. A pulse or holdoff in progress completes.
REQ-034 Pulse length and holdoff values are sampled on PULSE entry; later changes affect the next pulse only.

Reset
REQ-035 Asserting i_aresetn low, at any time including mid-pulse, immediately forces o_trigger=0, o_busy=0, o_missed=0, o_trig_count=0, state IDLE, and all synchronisers, debounce, divider and timer registers to 0.
REQ-036 After release, a source already high produces a rising edge once it propagates, as if it had risen from 0.

Structure
REQ-037 Package trig_gen_pkg holds the state enum (IDLE, PULSE, HOLDOFF) and the edge-mode enum with its encodings.
REQ-038 The debouncer is the sub-module trig_debounce (parameter CNT_W; inputs: value, reload, length; output: stable value). It is instantiated once, after the mux.

Verification
REQ-039 N_SRC=4, sel=2, rising mode, deb=0, div=1, pulse_len=3, holdoff=0; one rising edge on i_src[2] -> o_trigger high 3 cycles starting at latency 4; o_trig_count=1.
REQ-040 deb=5; glitches on the selected source of 4 cycles -> no trigger. A 6-cycle high level -> exactly 1 pulse.
REQ-041 div=3, both-edges mode; 6 edges, well spaced -> exactly 2 pulses, on the 3rd and 6th edges.
REQ-042 pulse_len=4, holdoff=10; a second edge 6 cycles after the first fire -> no second pulse, o_missed=1 for one cycle, o_busy high for 14 cycles.
REQ-043 Simultaneous hardware fire and i_soft_trig -> one pulse, count+1. Reset asserted on the 2nd pulse cycle -> o_trigger 0 immediately and count 0.
REQ-044 Switch i_sel to a source held high, rising mode -> no pulse. A subsequent genuine edge on the new source -> 1 pulse.
